dm_wbuf: RTL

DM_WBUF -- requirements
Module: dm_wbuf

---
 rtl/dm_wbuf_if.sv | 34 +++
 rtl/dm_wbuf.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dm_wbuf_if.sv
// Core and memory request buses for the posted-store write buffer.
// A core request is taken on a rising edge where core_enable=1 and core_stall=0; a memory
// request is held stable until an edge where mem_ready=1, which completes it.
interface dm_wbuf_if;
  logic        core_enable;
  logic        core_read;
  logic        core_write;
  logic [11:0] core_address;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic        mem_enable;
  logic        mem_read;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  core_enable, core_read, core_write, core_address, core_wdata,
    input  mem_rdata, mem_ready,
    output core_stall, core_rdata, core_rvalid,
    output mem_enable, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output core_enable, core_read, core_write, core_address, core_wdata,
    output mem_rdata, mem_ready,
    input  core_stall, core_rdata, core_rvalid,
    input  mem_enable, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/dm_wbuf.sv
// Posted-store write buffer between core and data memory; loads take priority over drain.
// Define DM_WBUF_FORWARD_EN to build store-to-load forwarding from buffered entries.
module dm_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  dm_wbuf_if.slave                   bus,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_BUSY = 2'd1, RD_BUSY = 2'd2} state_t;

  state_t        state;
  logic [11:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic        is_store;
  logic        is_load;
  logic        push;
  logic        pop;
  logic        full;
  logic        rd_done;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        load_go;

  assign is_store = bus.core_enable & bus.core_write;
  assign is_load  = bus.core_enable & bus.core_read & ~bus.core_write;
  assign pop      = (state == WR_BUSY) & bus.mem_ready;
  assign rd_done  = (state == RD_BUSY) & bus.mem_ready;
  assign full     = (count == CW'(DEPTH));
  // A full buffer still takes a store in the cycle its head retires.
  assign push     = is_store & (~full | pop);

`ifdef DM_WBUF_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_q[head + PW'(i)] == bus.core_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + PW'(i)];
      end
    end
  end
  assign load_go = is_load & ~fwd_hit;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // Without forwarding a load may only reach memory once every older store has drained.
  assign load_go  = is_load & (count == '0);
`endif

  assign bus.core_stall = ~reset & ((is_store & ~push) | (is_load & ~fwd_hit & ~rd_done));
  assign dbg_state      = state;
  assign dbg_count      = count;

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail] <= bus.core_address;
      data_q[tail] <= bus.core_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      bus.core_rdata  <= '0;
      bus.core_rvalid <= 1'b0;
      bus.mem_enable  <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      bus.core_rvalid <= (is_load & fwd_hit) | rd_done;
      if (is_load & fwd_hit) bus.core_rdata <= fwd_data;
      else if (rd_done)      bus.core_rdata <= bus.mem_rdata;

      case (state)
        IDLE: begin
          if (load_go) begin
            state           <= RD_BUSY;
            bus.mem_enable  <= 1'b1;
            bus.mem_read    <= 1'b1;
            bus.mem_address <= bus.core_address;
            bus.mem_wdata   <= '0;
          end else if (count != '0) begin
            state           <= WR_BUSY;
            bus.mem_enable  <= 1'b1;
            bus.mem_write   <= 1'b1;
            bus.mem_address <= addr_q[head];
            bus.mem_wdata   <= data_q[head];
          end
        end
        WR_BUSY, RD_BUSY: begin
          if (bus.mem_ready) begin
            state           <= IDLE;
            bus.mem_enable  <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
